// File: rtl/l2_cache_responder_pkg.sv
// Shared encodings, widths and the queued request record for the L2 cache responder.
package l2_cache_responder_pkg;

  localparam int LINE_W   = 512;
  localparam int MASK_W   = LINE_W / 8;
  localparam int ADDR_W   = 26;
  localparam int UNIT_W   = 2;
  localparam int STRAND_W = 2;
  localparam int WAY_W    = 2;
  localparam int NUM_RES  = 1 << (UNIT_W + STRAND_W);

  typedef enum logic [2:0] {
    PCI_LOAD   = 3'd0,
    PCI_STORE  = 3'd1,
    PCI_SLOAD  = 3'd2,
    PCI_SSTORE = 3'd3
  } pci_op_e;

  typedef enum logic [1:0] {
    CPI_LOAD_DONE   = 2'd0,
    CPI_STORE_DONE  = 2'd1,
    CPI_SSTORE_FAIL = 2'd2
  } cpi_op_e;

  typedef struct packed {
    logic [UNIT_W-1:0]   unit;
    logic [STRAND_W-1:0] strand;
    logic [2:0]          op;
    logic [WAY_W-1:0]    way;
    logic [ADDR_W-1:0]   addr;
    logic [LINE_W-1:0]   data;
    logic [MASK_W-1:0]   mask;
  } req_t;

  localparam int REQ_W = $bits(req_t);

  function automatic logic [LINE_W-1:0] merge_line(input logic [LINE_W-1:0] old_line,
                                                   input logic [LINE_W-1:0] wr_data,
                                                   input logic [MASK_W-1:0] wr_mask);
    logic [LINE_W-1:0] merged;
    merged = old_line;
    for (int i = 0; i < MASK_W; i++) begin
      if (wr_mask[i]) merged[8*i +: 8] = wr_data[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/l2_cache_responder_fifo.sv
// Generic synchronous FIFO; full is registered, so a pop never frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] slot_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = slot_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_ok) slot_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/l2_cache_responder.sv
// L2 cache responder: queued requests served one at a time with load-reserved/store-conditional.
// Define L2_STORE_UPDATE_EN to return the post-merge line on successful store responses.
module l2_cache_responder
  import l2_cache_responder_pkg::*;
#(
  parameter int MEM_LINES  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pci_valid_i,
  input  logic [1:0]    pci_unit_i,
  input  logic [1:0]    pci_strand_i,
  input  logic [2:0]    pci_op_i,
  input  logic [1:0]    pci_way_i,
  input  logic [25:0]   pci_address_i,
  input  logic [511:0]  pci_data_i,
  input  logic [63:0]   pci_mask_i,
  output logic          pci_ack_o,
  output logic          cpi_valid_o,
  output logic [1:0]    cpi_unit_o,
  output logic [1:0]    cpi_strand_o,
  output logic [1:0]    cpi_op_o,
  output logic          cpi_update_o,
  output logic [1:0]    cpi_way_o,
  output logic [511:0]  cpi_data_o
);

  localparam int IDX_W = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESPOND} state_e;

  state_e state_q, state_d;

  req_t             req_in, head, req_q;
  logic [REQ_W-1:0] fifo_dout;
  logic             fifo_full, fifo_empty, fifo_pop;

  assign req_in    = {pci_unit_i, pci_strand_i, pci_op_i, pci_way_i,
                      pci_address_i, pci_data_i, pci_mask_i};
  assign head      = fifo_dout;
  assign pci_ack_o = pci_valid_i && !fifo_full;

  sync_fifo #(.WIDTH(REQ_W), .DEPTH(FIFO_DEPTH)) u_req_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (pci_ack_o),
    .data_i  (req_in),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = S_ACCESS;
        end
      end
      S_ACCESS:  state_d = S_RESPOND;
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      if (fifo_pop) req_q <= head;
    end
  end

  logic [LINE_W-1:0] mem_q [MEM_LINES];
  logic              res_valid_q [NUM_RES];
  logic [ADDR_W-1:0] res_addr_q  [NUM_RES];

  logic [IDX_W-1:0]                 mem_idx;
  logic [UNIT_W+STRAND_W-1:0]       res_idx;
  logic [LINE_W-1:0]                old_line, new_line, rsp_data;
  logic                             do_access, is_sload, is_sstore, own_res_hit, store_ok;
  logic                             rsp_update;
  cpi_op_e                          rsp_op;

  always_comb begin
    do_access   = (state_q == S_ACCESS);
    mem_idx     = req_q.addr[IDX_W-1:0];
    res_idx     = {req_q.unit, req_q.strand};
    old_line    = mem_q[mem_idx];
    new_line    = merge_line(old_line, req_q.data, req_q.mask);
    is_sload    = (req_q.op == PCI_SLOAD);
    is_sstore   = (req_q.op == PCI_SSTORE);
    own_res_hit = res_valid_q[res_idx] && (res_addr_q[res_idx] == req_q.addr);
    store_ok    = (req_q.op == PCI_STORE) || (is_sstore && own_res_hit);
    rsp_op      = CPI_LOAD_DONE;
    rsp_update  = 1'b0;
    rsp_data    = old_line;
    if (store_ok) begin
      rsp_op = CPI_STORE_DONE;
`ifdef L2_STORE_UPDATE_EN
      rsp_update = 1'b1;
      rsp_data   = new_line;
`else
      rsp_update = 1'b0;
      rsp_data   = '0;
`endif
    end else if (is_sstore) begin
      rsp_op   = CPI_SSTORE_FAIL;
      rsp_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_access && store_ok) mem_q[mem_idx] <= new_line;
  end

  // Any successful store to an address kills every reservation on it, the writer's own included.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_RES; k++) begin
        res_valid_q[k] <= 1'b0;
        res_addr_q[k]  <= '0;
      end
    end else if (do_access) begin
      if (is_sload) begin
        res_valid_q[res_idx] <= 1'b1;
        res_addr_q[res_idx]  <= req_q.addr;
      end else if (store_ok) begin
        for (int k = 0; k < NUM_RES; k++) begin
          if (res_valid_q[k] && (res_addr_q[k] == req_q.addr)) res_valid_q[k] <= 1'b0;
        end
      end
    end
  end

  logic [1:0]        cpi_unit_q, cpi_strand_q, cpi_way_q;
  cpi_op_e           cpi_op_q;
  logic              cpi_update_q;
  logic [LINE_W-1:0] cpi_data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpi_unit_q   <= '0;
      cpi_strand_q <= '0;
      cpi_way_q    <= '0;
      cpi_op_q     <= CPI_LOAD_DONE;
      cpi_update_q <= 1'b0;
      cpi_data_q   <= '0;
    end else if (do_access) begin
      cpi_unit_q   <= req_q.unit;
      cpi_strand_q <= req_q.strand;
      cpi_way_q    <= req_q.way;
      cpi_op_q     <= rsp_op;
      cpi_update_q <= rsp_update;
      cpi_data_q   <= rsp_data;
    end
  end

  assign cpi_valid_o  = (state_q == S_RESPOND);
  assign cpi_unit_o   = cpi_unit_q;
  assign cpi_strand_o = cpi_strand_q;
  assign cpi_way_o    = cpi_way_q;
  assign cpi_op_o     = cpi_op_q;
  assign cpi_update_o = cpi_update_q;
  assign cpi_data_o   = cpi_data_q;

endmodule

// File: tb/tb_l2_cache_responder.sv
// Self-checking bench: directed scenarios plus randomized traffic against a request-level model.
module tb_l2_cache_responder;

`ifdef L2_STORE_UPDATE_EN
  localparam bit UPD_EN = 1'b1;
`else
  localparam bit UPD_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         pci_valid_i = 1'b0;
  logic [1:0]   pci_unit_i = '0, pci_strand_i = '0, pci_way_i = '0;
  logic [2:0]   pci_op_i = '0;
  logic [25:0]  pci_address_i = '0;
  logic [511:0] pci_data_i = '0;
  logic [63:0]  pci_mask_i = '0;
  logic         pci_ack_o, cpi_valid_o, cpi_update_o;
  logic [1:0]   cpi_unit_o, cpi_strand_o, cpi_op_o, cpi_way_o;
  logic [511:0] cpi_data_o;

  l2_cache_responder dut (
    .clk(clk), .reset_n(reset_n),
    .pci_valid_i(pci_valid_i), .pci_unit_i(pci_unit_i), .pci_strand_i(pci_strand_i),
    .pci_op_i(pci_op_i), .pci_way_i(pci_way_i), .pci_address_i(pci_address_i),
    .pci_data_i(pci_data_i), .pci_mask_i(pci_mask_i), .pci_ack_o(pci_ack_o),
    .cpi_valid_o(cpi_valid_o), .cpi_unit_o(cpi_unit_o), .cpi_strand_o(cpi_strand_o),
    .cpi_op_o(cpi_op_o), .cpi_update_o(cpi_update_o), .cpi_way_o(cpi_way_o),
    .cpi_data_o(cpi_data_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;
  int stall_cnt = 0;
  int last_lat = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: flat memory plus reservation table, evaluated in acceptance order.
  typedef struct {
    logic [1:0]   unit, strand, way, op;
    logic         upd;
    logic [511:0] data;
    bit           chk_data;
    int           acc;
  } exp_t;

  logic [511:0] m_mem [64];
  bit           m_known [64];
  bit           m_res_v [16];
  logic [25:0]  m_res_a [16];
  exp_t         exp_q [$];

  task automatic model_clear();
    for (int k = 0; k < 16; k++) m_res_v[k] = 1'b0;
    for (int k = 0; k < 64; k++) m_known[k] = 1'b0;
  endtask

  task automatic model_accept(input logic [1:0] u, input logic [1:0] s, input logic [1:0] w,
                              input logic [2:0] op, input logic [25:0] a,
                              input logic [511:0] d, input logic [63:0] m, input int acc);
    exp_t e;
    int   idx = int'(a) % 64;
    int   r   = int'(u) * 4 + int'(s);
    bit   st_ok = (op == 3'd1) || (op == 3'd3 && m_res_v[r] && m_res_a[r] == a);
    e.unit = u; e.strand = s; e.way = w; e.acc = acc;
    if (st_ok) begin
      for (int i = 0; i < 64; i++) if (m[i]) m_mem[idx][8*i +: 8] = d[8*i +: 8];
      if (m == {64{1'b1}}) m_known[idx] = 1'b1;
      for (int k = 0; k < 16; k++) if (m_res_v[k] && m_res_a[k] == a) m_res_v[k] = 1'b0;
      e.op = 2'd1; e.upd = UPD_EN;
      e.data = UPD_EN ? m_mem[idx] : '0;
      e.chk_data = UPD_EN ? m_known[idx] : 1'b1;
    end else if (op == 3'd3) begin
      e.op = 2'd2; e.upd = 1'b0; e.data = '0; e.chk_data = 1'b1;
    end else begin
      if (op == 3'd2) begin m_res_v[r] = 1'b1; m_res_a[r] = a; end
      e.op = 2'd0; e.upd = 1'b0; e.data = m_mem[idx]; e.chk_data = m_known[idx];
    end
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [1:0] u, input logic [1:0] s, input logic [1:0] w,
                       input logic [2:0] op, input logic [25:0] a,
                       input logic [511:0] d, input logic [63:0] m);
    int waited = 0;
    @(negedge clk);
    pci_valid_i = 1'b1; pci_unit_i = u; pci_strand_i = s; pci_way_i = w;
    pci_op_i = op; pci_address_i = a; pci_data_i = d; pci_mask_i = m;
    #1;
    while (!pci_ack_o && waited < 200) begin
      stall_cnt++;
      @(negedge clk); #1;
      waited++;
    end
    check("ack_timeout", pci_ack_o, 1'b1);
    if (pci_ack_o) model_accept(u, s, w, op, a, d, m, cyc);
  endtask

  task automatic idle();
    @(negedge clk);
    pci_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk); #2;
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Response monitor: in-order scoreboard, latency floor, and hold-when-idle.
  exp_t         mon_e;
  logic [1:0]   last_unit = '0, last_strand = '0, last_way = '0, last_op = '0;
  logic         last_upd = 1'b0;
  logic [511:0] last_data = '0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (cpi_valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", cpi_valid_o, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_unit", cpi_unit_o, mon_e.unit);
          check("rsp_strand", cpi_strand_o, mon_e.strand);
          check("rsp_way", cpi_way_o, mon_e.way);
          check("rsp_op", cpi_op_o, mon_e.op);
          check("rsp_update", cpi_update_o, mon_e.upd);
          if (mon_e.chk_data) check("rsp_data", cpi_data_o, mon_e.data);
          last_lat = cyc - mon_e.acc;
          check("latency_min3", (last_lat >= 3), 1'b1);
        end
        last_unit = cpi_unit_o; last_strand = cpi_strand_o; last_way = cpi_way_o;
        last_op = cpi_op_o; last_upd = cpi_update_o; last_data = cpi_data_o;
      end else begin
        check("hold_unit", cpi_unit_o, last_unit);
        check("hold_op", cpi_op_o, last_op);
        check("hold_update", cpi_update_o, last_upd);
        check("hold_data", cpi_data_o, last_data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  logic [25:0] atab [6];
  logic [511:0] line_a5;
  int rnd;
  logic [2:0] rop;

  initial begin
    atab[0] = 26'h40;  atab[1] = 26'h80;      atab[2] = 26'h440;
    atab[3] = 26'h5;   atab[4] = 26'h3FFFFC5; atab[5] = 26'h0;
    line_a5 = {64{8'hA5}};
    model_clear();

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", cpi_valid_o, 1'b0);
    check("rst_ack", pci_ack_o, 1'b0);
    check("rst_data", cpi_data_o, '0);
    check("rst_op", cpi_op_o, 2'd0);
    check("rst_update", cpi_update_o, 1'b0);
    reset_n = 1'b1;

    // Fill every line with known data
    for (int n = 0; n < 64; n++)
      issue(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            3'd1, 26'(n) | (26'($urandom_range(0, 7)) << 6), rand_line(), {64{1'b1}});
    idle(); drain();

    // Full-line store then load on line 5, idle-queue latency
    issue(2'd0, 2'd0, 2'd1, 3'd1, 26'h5, line_a5, {64{1'b1}});
    idle(); drain();
    issue(2'd0, 2'd0, 2'd1, 3'd0, 26'h5, '0, '0);
    idle(); drain();
    check("load_latency_eq3", last_lat, 3);
    check("line5_a5", last_data, line_a5);

    // Single-byte masked store
    issue(2'd2, 2'd1, 2'd0, 3'd1, 26'h5, {{63{8'hFF}}, 8'h3C}, 64'h1);
    issue(2'd2, 2'd1, 2'd0, 3'd0, 26'h5, '0, '0);
    idle(); drain();
    check("line5_byte0", last_data, {{63{8'hA5}}, 8'h3C});

    // Reserved load/store-conditional: success then repeat failure
    issue(2'd1, 2'd2, 2'd3, 3'd2, 26'h40, '0, '0);
    issue(2'd1, 2'd2, 2'd3, 3'd3, 26'h40, rand_line(), {64{1'b1}});
    issue(2'd1, 2'd2, 2'd3, 3'd3, 26'h40, rand_line(), {64{1'b1}});
    idle(); drain();
    check("sstore_repeat_fail", last_op, 2'd2);
    issue(2'd1, 2'd2, 2'd3, 3'd0, 26'h40, '0, '0);
    idle(); drain();

    // Another unit's plain store kills the reservation
    issue(2'd0, 2'd0, 2'd0, 3'd2, 26'h80, '0, '0);
    issue(2'd1, 2'd0, 2'd0, 3'd2, 26'h80, '0, '0);
    issue(2'd0, 2'd0, 2'd0, 3'd1, 26'h80, rand_line(), 64'hFFFF_0000_FFFF_0000);
    issue(2'd1, 2'd0, 2'd0, 3'd3, 26'h80, rand_line(), {64{1'b1}});
    idle(); drain();
    check("sstore_after_kill", last_op, 2'd2);

    // Eight back-to-back requests overflow the queue
    stall_cnt = 0;
    for (int n = 0; n < 8; n++)
      issue(2'(n), 2'(n >> 2), 2'(n + 1), 3'(n[0] ? 3'd0 : 3'd5), 26'(8 + n), '0, '0);
    idle(); drain();
    check("ack_low_when_full", (stall_cnt > 0), 1'b1);

    // Randomized traffic over a small, aliasing address set
    for (int n = 0; n < 200; n++) begin
      rnd = $urandom_range(0, 9);
      rop = (rnd < 2) ? 3'd0 : (rnd < 4) ? 3'd1 : (rnd < 6) ? 3'd2 :
            (rnd < 9) ? 3'd3 : 3'($urandom_range(4, 7));
      issue(2'($urandom_range(0, 1)), 2'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            rop, atab[$urandom_range(0, 5)], rand_line(),
            {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) begin
        idle();
        repeat ($urandom_range(0, 4)) @(negedge clk);
      end
    end
    idle(); drain();

    // Reset during ACCESS drops the request and all reservations
    issue(2'd3, 2'd3, 2'd0, 3'd2, 26'h80, '0, '0);
    idle(); drain();
    issue(2'd0, 2'd0, 2'd0, 3'd0, 26'h5, '0, '0);
    idle();
    @(negedge clk);
    reset_n = 1'b0;
    exp_q.delete();
    model_clear();
    last_unit = '0; last_strand = '0; last_way = '0; last_op = '0;
    last_upd = 1'b0; last_data = '0;
    #1;
    check("midrst_valid", cpi_valid_o, 1'b0);
    check("midrst_data", cpi_data_o, '0);
    check("midrst_unit", cpi_unit_o, 2'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk); #1;
      check("no_rsp_after_rst", cpi_valid_o, 1'b0);
    end
    issue(2'd3, 2'd3, 2'd0, 3'd3, 26'h80, rand_line(), {64{1'b1}});
    issue(2'd1, 2'd1, 2'd2, 3'd1, 26'h7, rand_line(), {64{1'b1}});
    issue(2'd1, 2'd1, 2'd2, 3'd0, 26'h7, '0, '0);
    idle(); drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/l2_cache_responder.md
L2_CACHE_RESPONDER -- requirements
Module: l2_cache_responder

Interface
REQ-001 Parameter MEM_LINES, default 64, SHALL be the number of 512-bit lines in the backing store (power of two, at most 2^26).
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL be the request queue depth (power of two, at least 2).
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset_n  in  1  SHALL be an asynchronous, active-low reset.
REQ-005 pci_valid_i, pci_unit_i[1:0], pci_strand_i[1:0], pci_op_i[2:0], pci_way_i[1:0], pci_address_i[25:0], pci_data_i[511:0], pci_mask_i[63:0]  in  SHALL carry one request; address is a line address.
REQ-006 pci_ack_o  out  1  SHALL indicate the request was accepted this cycle.
REQ-007 cpi_valid_o, cpi_unit_o[1:0], cpi_strand_o[1:0], cpi_op_o[1:0], cpi_update_o, cpi_way_o[1:0], cpi_data_o[511:0]  out  SHALL carry one single-cycle response.

Function
REQ-008 pci_op encodings SHALL be: 0 load, 1 store, 2 synchronized load, 3 synchronized store; 4-7 reserved.
REQ-009 cpi_op encodings SHALL be: 0 load done, 1 store done, 2 synchronized store failed.
REQ-010 pci_ack_o SHALL be combinational: pci_valid_i && queue not full; accepted requests SHALL enter the FIFO in order.
REQ-011 A full FIFO SHALL hold pci_ack_o low; a dequeue in the same cycle SHALL NOT free a slot until the next cycle.
REQ-012 The service FSM SHALL have states IDLE, ACCESS, RESPOND: IDLE->ACCESS when FIFO non-empty (pop head); ACCESS->RESPOND after one cycle; RESPOND->IDLE after one cycle.
REQ-013 cpi_valid_o SHALL be high only in RESPOND, exactly one cycle per request; minimum latency from accept to response is 3 cycles.
REQ-014 Unit, strand and way of the response SHALL equal those of the request.
REQ-015 Memory index SHALL be pci_address[log2(MEM_LINES)-1:0]; upper bits SHALL be ignored.
REQ-016 Load and synchronized load SHALL return the stored line on cpi_data_o with cpi_op 0 and cpi_update_o 0.
REQ-017 Store SHALL write byte i (data[8i+7:8i]) only where mask bit i is 1, in ACCESS.
REQ-018 Synchronized load SHALL set reservation[unit,strand] := {valid, full address}.
REQ-019 Synchronized store SHALL succeed only if its own reservation is valid and matches the address; failure SHALL leave memory unchanged and respond cpi_op 2.
REQ-020 Every successful store SHALL clear all reservations whose address matches, including its own.
REQ-021 Reserved ops SHALL be treated as loads.
REQ-022 Outputs other than cpi_valid_o and pci_ack_o SHALL hold their last value outside RESPOND.

Reset
REQ-023 Reset SHALL empty the FIFO, clear all reservations, force IDLE and zero all cpi outputs; memory contents SHALL be undefined.
REQ-024 Reset mid-operation SHALL drop in-flight requests with no response.

Configuration
REQ-025 With L2_STORE_UPDATE_EN defined, a successful store SHALL respond with cpi_update_o 1 and cpi_data_o = post-merge line.
REQ-026 Without L2_STORE_UPDATE_EN, store responses SHALL have cpi_update_o 0 and cpi_data_o 0.

Structure
REQ-027 Shared package SHALL hold pci/cpi op encodings and line/mask width constants.
REQ-028 The request queue SHALL be one sub-module, sync_fifo, parameterized by width and depth.

Verification
REQ-029 Store line 5 with all mask bits 1, data 0xA5 repeated, then load line 5 -> cpi_op 0, data 0xA5 repeated, 3 cycles after acceptance.
REQ-030 Store line 5 with mask 0x1, data byte 0 = 0x3C -> subsequent load returns byte 0 = 0x3C, bytes 1-63 unchanged.
REQ-031 Unit 1 strand 2 sync load on addr 0x40, then sync store on 0x40 -> cpi_op 1; a repeat sync store -> cpi_op 2, memory unchanged.
REQ-032 Sync loads by units 0 and 1 on 0x80; unit 0 plain store on 0x80; unit 1 sync store -> cpi_op 2.
REQ-033 Eight back-to-back requests with FIFO_DEPTH 4 -> pci_ack_o low while full; eight in-order responses.
REQ-034 With L2_STORE_UPDATE_EN on, then off, store -> cpi_update_o 1 with merged data, then 0 with zero data; reset_n low mid-ACCESS -> no cpi_valid_o.
